// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the jz pipeline control unit.
// Stage indices, FSM encoding and default geometry.
package pipe_ctrl_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int DEF_STAGES = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline and pipe_ctrl.
// master = pipeline side, slave = controller side.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int MC_W   = 6
);

  logic [STAGES-1:0] stallreq_i;
  logic              mc_start_i;
  logic [MC_W-1:0]   mc_cycles_i;
  logic              flush_i;
  logic [31:0]       new_pc_i;

  logic [STAGES-1:0] stall_o;
  logic              flush_o;
  logic              pc_load_o;
  logic [31:0]       pc_o;
  logic              mc_busy_o;
  logic              wdog_o;

  modport master (
    output stallreq_i, mc_start_i, mc_cycles_i,
    output flush_i, new_pc_i,
    input  stall_o, flush_o, pc_load_o,
    input  pc_o, mc_busy_o, wdog_o
  );

  modport slave (
    input  stallreq_i, mc_start_i, mc_cycles_i,
    input  flush_i, new_pc_i,
    output stall_o, flush_o, pc_load_o,
    output pc_o, mc_busy_o, wdog_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_therm.sv
// Priority-to-thermometer encoder: every bit at or below
// the highest set request bit is driven high.
module stall_therm #(
  parameter int STAGES = 6
) (
  input  logic [STAGES-1:0] req,
  output logic [STAGES-1:0] therm
);

  logic acc;

  always_comb begin
    acc   = 1'b0;
    therm = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc      = acc | req[j];
      therm[j] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, multi-cycle countdown,
// registered flush/redirect and stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES   = DEF_STAGES,
  parameter int MC_STAGE = STG_EX,
  parameter int MC_W     = 6,
  parameter int WD_W     = 8,
  parameter int WD_LIMIT = 200
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WD_LIMIT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  state_t            state, nxt;
  logic [MC_W-1:0]   cnt, cnt_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic [31:0]       pc_q;
  logic              wdog_q;
  logic              busy;
  logic              flushing;
  logic [STAGES-1:0] req;
  logic [STAGES-1:0] therm;
  logic              stall_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // flush wins over everything and kills any op in flight
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    if (bus.flush_i) begin
      nxt     = ST_FLUSH;
      cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.mc_start_i && bus.mc_cycles_i != '0) begin
            nxt     = ST_MC_BUSY;
            cnt_nxt = bus.mc_cycles_i;
          end
        end
        ST_MC_BUSY: begin
          if (cnt <= MC_W'(1)) begin
            nxt     = ST_IDLE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          nxt     = ST_IDLE;
          cnt_nxt = '0;
        end
        default: begin
          nxt     = ST_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    flushing = 1'b0;
    unique case (state)
      ST_MC_BUSY: busy     = 1'b1;
      ST_FLUSH:   flushing = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    req           = bus.stallreq_i;
    req[MC_STAGE] = req[MC_STAGE] | busy;
  end

  stall_therm #(.STAGES(STAGES)) u_therm (
    .req   (req),
    .therm (therm)
  );

  assign stall_any = |bus.stall_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (bus.flush_i) begin
      pc_q <= bus.new_pc_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      wdog_q <= 1'b0;
    end else begin
      if (!stall_any) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (stall_any && wd_cnt >= WD_TRIP) begin
        wdog_q <= 1'b1;
      end
    end
  end

  assign bus.stall_o   = flushing ? '0 : therm;
  assign bus.flush_o   = flushing;
  assign bus.pc_load_o = flushing;
  assign bus.pc_o      = pc_q;
  assign bus.mc_busy_o = busy;
  assign bus.wdog_o    = wdog_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the jz core family; successor to the fixed 6-bit, ID-only stall controller.
- Merges per-stage stall requests and an internal multi-cycle-op countdown into a thermometer stall vector.
- Adds a registered flush/redirect path (exception or trap return) and a stall watchdog.
- Sits beside the pipeline registers; drives their stall/flush inputs and the PC redirect.

Parameters:
- STAGES, 6, number of pipeline stages including PC (bit 0 = PC, bit STAGES-1 = WB).
- MC_STAGE, 3, stage index at which a multi-cycle op (div/mul) is held.
- MC_W, 6, width of the multi-cycle count.
- WD_W, 8, width of the watchdog counter.
- WD_LIMIT, 200, consecutive stalled cycles before the watchdog fires.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stallreq_i  in  STAGES  bit k = stage k requests a stall this cycle
- mc_start_i  in  1  pulse: multi-cycle op enters MC_STAGE
- mc_cycles_i  in  MC_W  extra cycles the op needs; 0 = no stall
- flush_i  in  1  pulse: redirect request
- new_pc_i  in  32  redirect target
- stall_o  out  STAGES  stall vector to PC and pipeline registers
- flush_o  out  1  clear all pipeline registers
- pc_load_o  out  1  PC loads pc_o this cycle
- pc_o  out  32  registered redirect target
- mc_busy_o  out  1  countdown active
- wdog_o  out  1  sticky watchdog event

Behaviour:
- Reset: stall_o=0, flush_o=0, pc_load_o=0, pc_o=0, mc_busy_o=0, wdog_o=0, counters 0, state IDLE. wdog_o clears only on rst.
- Effective request vector r = stallreq_i | (mc_busy_o << MC_STAGE).
- stall_o[j] = 1 for every j <= highest set bit of r; otherwise 0. Combinational from r. Forced to all-zero while flush_o=1.
- States: IDLE, MC_BUSY, FLUSH.
- IDLE:
  - mc_start_i with mc_cycles_i != 0: load counter = mc_cycles_i, go to MC_BUSY.
  - mc_cycles_i = 0: ignored.
- MC_BUSY:
  - mc_busy_o=1; counter decrements each cycle.
  - At counter = 1, go to IDLE next edge. An op with N cycles asserts mc_busy_o for exactly N cycles starting the cycle after mc_start_i.
  - mc_start_i while busy is ignored; ctrl is stalling the stage, so this is a protocol error.
- Flush:
  - flush_i (any state) captures new_pc_i into pc_o and enters FLUSH next edge.
  - FLUSH lasts exactly 1 cycle: flush_o=1, pc_load_o=1. It then returns to IDLE with the counter cleared, so an in-flight multi-cycle op is killed.
  - flush_i during FLUSH: recapture pc_o and stay in FLUSH one more cycle (latest target wins).
- Priority: flush_i > mc_start_i > countdown. Simultaneous flush_i and mc_start_i discards the op.
- Watchdog:
  - Counter increments each cycle any stall_o bit is 1; resets to 0 on any cycle with stall_o=0.
  - Saturates at 2^WD_W-1.
  - Reaching WD_LIMIT sets wdog_o=1 and does not flush; software or the exception unit reacts.
- Widths: counters unsigned, no wrap. WD_LIMIT must be < 2^WD_W; MC_STAGE must be < STAGES.
- Reset mid-operation: asynchronous. All state clears immediately; no pending flush survives.

Decomposition:
- Shared package/define file: stage index constants (STG_PC, STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB), state encodings, default STAGES.
- Sub-module: stall_therm (priority-to-thermometer encoder, STAGES wide). The FSM and counters stay in pipe_ctrl.

Test Plan:
- stallreq_i=6'b000100 (STAGES=6) -> stall_o=6'b000111; stallreq_i=6'b100001 -> stall_o=6'b111111; stallreq_i=0 -> stall_o=0.
- mc_start_i with mc_cycles_i=4, no other requests -> mc_busy_o high for 4 cycles starting next cycle; stall_o=6'b001111 during those cycles; then 0.
- flush_i with new_pc_i=32'hBFC00380 on the 2nd busy cycle of a 10-cycle op -> next cycle flush_o=1, pc_load_o=1, pc_o=BFC00380, stall_o=0; following cycle mc_busy_o=0 and all outputs idle.
- Back-to-back flush_i with new_pc_i=0x100 then 0x200 -> FLUSH held 2 cycles; pc_o=0x200 on the final flush cycle.
- stallreq_i[2] held 200 cycles (WD_LIMIT=200) -> wdog_o rises on the 200th stalled cycle and stays high after the request drops; held 199 cycles then released -> wdog_o stays 0.
- Assert rst asynchronously mid-countdown and mid-FLUSH -> all outputs 0 immediately, without waiting for a clock edge; after release, mc_start_i with mc_cycles_i=2 behaves normally.
